// File: rtl/counter_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched_pkg
// Purpose  : Shared types and helpers for the counter scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package counter_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a requester index; never zero even for a single requester
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches req upward starting
//            just after the last winner, wrapping, and returns a one-hot
//            grant plus its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
   import counter_sched_pkg::*;
#(
   parameter int N    = 4,
   localparam int ID_W = id_width(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] last,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id
);

   // First asserted request after 'last', wrapping; at most one grant bit
   always_comb begin : arb_search
      logic found;
      int   idx;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last) + k) % N;
         if (!found && req[idx]) begin
            found       = 1'b1;
            gnt[idx]    = 1'b1;
            gnt_id      = ID_W'(idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : counter_sched
// Purpose  : Shares one WIDTH-bit up-counter among NUM_REQ requesters.
//            Requests are granted round-robin; the counter runs from 0 to
//            the winner's length, then a one-cycle done pulse is returned.
// Options  : define COUNTER_SCHED_PRESCALE_EN to add a 'prescale' input that
//            slows counting to one step every prescale+1 cycles.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_len,
   input  logic                     abort,
`ifdef COUNTER_SCHED_PRESCALE_EN
   input  logic [WIDTH-1:0]         prescale,
`endif
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id,
   output logic [WIDTH-1:0]         count
);

   state_t             state;
   logic [WIDTH-1:0]   len_q;
   logic [WIDTH-1:0]   count_q;
   logic [ID_W-1:0]    grant_q;
   logic [ID_W-1:0]    last_q;
   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_id;
   logic [WIDTH-1:0]   sel_len;
   logic               transfer;
   logic               tick;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req    (req_valid),
      .last   (last_q),
      .gnt    (arb_gnt),
      .gnt_id (arb_id)
   );

   // Arbiter result is only offered while idle
   assign req_ready = (state == IDLE) ? arb_gnt : '0;
   assign transfer  = |(req_valid & req_ready);
   assign busy      = (state == RUN) || (state == DONE);
   assign grant_id  = grant_q;
   assign count     = count_q;

   // Pick the length field belonging to the arbiter winner
   always_comb begin
      sel_len = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) sel_len = req_len[i*WIDTH +: WIDTH];
      end
   end

   // One-hot completion pulse for the granted requester while in DONE
   always_comb begin
      done = '0;
      if (state == DONE) done[grant_q] = 1'b1;
   end

`ifdef COUNTER_SCHED_PRESCALE_EN
   logic [WIDTH-1:0] presc_q;
   logic [WIDTH-1:0] presc_lim_q;

   assign tick = (presc_q == presc_lim_q);

   // Prescaler: cleared and loaded at accept, wraps on every tick in RUN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_q     <= '0;
         presc_lim_q <= '0;
      end else if (transfer) begin
         presc_q     <= '0;
         presc_lim_q <= prescale;
      end else if (state == RUN) begin
         presc_q     <= tick ? '0 : presc_q + WIDTH'(1);
      end
   end
`else
   assign tick = 1'b1;
`endif

   // Scheduler FSM with length latch and shared counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         len_q   <= '0;
         count_q <= '0;
         grant_q <= '0;
         last_q  <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (transfer) begin
                  len_q   <= sel_len;
                  grant_q <= arb_id;
                  count_q <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               // Abort wins over completion; the aborted requester drops priority
               if (abort) begin
                  count_q <= '0;
                  last_q  <= grant_q;
                  state   <= IDLE;
               end else if (count_q == len_q) begin
                  state   <= DONE;
               end else if (tick) begin
                  count_q <= count_q + WIDTH'(1);
               end
            end
            DONE: begin
               last_q <= grant_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Scheduler that shares one WIDTH-bit up-counter among NUM_REQ requesters.
- Each requester asks for a timed interval of a given length. The block grants requesters round-robin, runs the counter from 0 to the requested length, then pulses done back to the winner.
- Sits between software/control agents and the counter datapath; the counter value is exported for observation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, counter and length width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; the block is held in reset while low.
- req_valid  input  NUM_REQ  per-requester interval request.
- req_len  input  NUM_REQ*WIDTH  packed lengths; requester i at [i*WIDTH +: WIDTH].
- abort  input  1  cancel the running interval.
- req_ready  output  NUM_REQ  one-hot accept; combinational, only in IDLE.
- done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- busy  output  1  high in RUN and DONE.
- grant_id  output  $clog2(NUM_REQ)  index of the current/last granted requester.
- count  output  WIDTH  current counter value.

Behaviour:
- Reset (reset low, async):
  - state=IDLE; count=0; done=0; busy=0; grant_id=0.
  - Latched length=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- States are IDLE, RUN and DONE.
- IDLE:
  - Round-robin arbiter picks the first asserted req_valid searching from last_grant+1 upward, wrapping.
  - req_ready[winner]=1 in the same cycle. The transfer occurs when req_valid[i] and req_ready[i] are both high.
  - On transfer: latch req_len[i], grant_id<=i, count<=0, go to RUN.
  - With no req_valid: stay in IDLE, req_ready=0.
- RUN:
  - If count == latched length: go to DONE, count holds.
  - Otherwise count<=count+1 on each tick.
  - A tick is every cycle, or the prescaled tick when the optional feature is enabled.
  - Requester inputs are ignored in RUN; deasserting req_valid has no effect.
- DONE:
  - done[grant_id]=1 for exactly one cycle; last_grant<=grant_id; go to IDLE. count holds its final value until the next grant.
- Latency, no prescale:
  - accept at cycle N; RUN begins N+1 with count=0; done pulses at cycle N+2+len.
  - len=0 gives done at N+2.
  - len=2^WIDTH-1 runs to all-ones with no wrap; the counter never exceeds the latched length.
- abort:
  - In RUN: next state IDLE, count<=0, no done pulse, last_grant<=grant_id so the aborted requester loses priority.
  - In IDLE or DONE: ignored. The done pulse in DONE is still emitted.
- Simultaneous requests: exactly one winner per IDLE cycle; the others wait. req_ready is never multi-hot.
- Back-to-back: minimum one IDLE cycle between consecutive intervals.

Optional Feature:
- Macro: COUNTER_SCHED_PRESCALE_EN.
- Defined:
  - Adds input prescale [WIDTH-1:0] and an internal prescaler, cleared on entry to RUN.
  - A tick occurs when the prescaler equals prescale; the prescaler then wraps to 0. The counter advances every prescale+1 cycles.
  - prescale is sampled at accept and held for the interval.
  - Latency becomes N+2+len*(prescale+1).
- Undefined: no prescale port; a tick occurs every RUN cycle.

Decomposition:
- Package counter_sched_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  - the function clog2-safe ID width (max(1,$clog2(NUM_REQ))).
- One sub-module, rr_arbiter: parameter N; inputs req[N-1:0] and last[ID-1:0]; outputs gnt one-hot and gnt_id. Purely combinational.
- counter_sched holds the FSM, length latch, counter and optional prescaler.

Test Plan:
- Reset then req_valid=4'b0001, len0=5 -> req_ready[0] at accept cycle N; count 0..5; done[0] at N+7; busy high N+1..N+7.
- req_valid=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; one done per interval; req_ready never multi-hot.
- len=0 on requester 2 -> done[2] at N+2; len=8'hFF -> count reaches FF, done at N+257, no wrap to 0.
- abort asserted at count=3 with len=10 -> back to IDLE next cycle, count=0, no done; a pending requester 1 is granted next.
- reset driven low mid-RUN at count=4 -> count=0, busy=0, done=0 immediately (asynchronous); requester 0 wins first after release.
- With COUNTER_SCHED_PRESCALE_EN, prescale=2, len=3 -> count steps every 3 cycles; done at N+11.
